// File: rtl/noc_port_requester.sv
// noc_port_requester: per-port flit FIFO plus IDLE/REQ/SEND requester for the NoC router arbiter.
// Define ERR_CNT_EN to build the saturating malformed-flit drop counter (err_count is 0 otherwise).
module noc_port_requester #(
    parameter int          DATA_W   = 32,
    parameter int          DEPTH    = 8,
    parameter logic [5:0]  PORT_SEL = 6'b000010
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_flit,
    input  logic [2:0]        in_id,
    input  logic [5:0]        grant,
    output logic              req,
    output logic [2:0]        flit_id,
    output logic [11:0]       length,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_flit,
    output logic [2:0]        out_id,
    output logic [7:0]        err_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] ID_HDR  = 3'b001;
    localparam logic [2:0] ID_TAIL = 3'b100;

    typedef enum logic [1:0] {IDLE, REQ, SEND} state_t;

    state_t state, state_nx;
    logic [DATA_W+2:0] mem [DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr;
    logic              empty, full, push, pop, send_pop, latch, granted;
    logic [2:0]        head_id;
    logic [DATA_W-1:0] head_data;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty     = wr_ptr == rd_ptr;
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready  = !full;
    assign push      = in_valid && !full;
    assign head_id   = mem[rd_ptr[AW-1:0]][DATA_W+2:DATA_W];
    assign head_data = mem[rd_ptr[AW-1:0]][DATA_W-1:0];
    assign flit_id   = empty ? 3'b000 : head_id;
    assign granted   = |(grant & PORT_SEL);

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        send_pop = 1'b0;
        latch    = 1'b0;
        case (state)
            IDLE: if (!empty) begin
                latch    = head_id == ID_HDR;
                pop      = head_id != ID_HDR;
                state_nx = head_id == ID_HDR ? REQ : IDLE;
            end
            REQ: state_nx = granted ? SEND : REQ;
            SEND: begin
                pop      = granted && !empty;
                send_pop = pop;
                state_nx = !granted ? REQ : (pop && head_id == ID_TAIL) ? IDLE : SEND;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {in_id, in_flit};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            req       <= 1'b0;
            length    <= '0;
            out_valid <= 1'b0;
            out_flit  <= '0;
            out_id    <= '0;
        end else begin
            state     <= state_nx;
            wr_ptr    <= push ? wr_ptr + {{AW{1'b0}}, 1'b1} : wr_ptr;
            rd_ptr    <= pop ? rd_ptr + {{AW{1'b0}}, 1'b1} : rd_ptr;
            req       <= state_nx != IDLE;
            length    <= latch ? head_data[11:0] : length;
            out_valid <= send_pop;
            out_flit  <= send_pop ? head_data : out_flit;
            out_id    <= send_pop ? head_id : out_id;
        end
    end

`ifdef ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) err_count <= '0;
        else if (state == IDLE && pop && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
`else
    assign err_count = 8'd0;
`endif
endmodule

// File: tb/tb_noc_port_requester.sv
// tb_noc_port_requester: directed checks of the port requester FIFO, handshake and reset behaviour.
module tb_noc_port_requester;
    localparam logic [5:0] PS = 6'b000010;
`ifdef ERR_CNT_EN
    localparam logic [31:0] ERR3 = 32'd3;
`else
    localparam logic [31:0] ERR3 = 32'd0;
`endif

    logic        clk, rst, in_valid, in_ready, req, out_valid;
    logic [31:0] in_flit, out_flit;
    logic [2:0]  in_id, flit_id, out_id;
    logic [5:0]  grant;
    logic [11:0] length;
    logic [7:0]  err_count;
    int          n_tests = 0;
    int          n_fail = 0;
    int          k, cnt;

    logic [2:0]  p1_id [4] = '{3'b001, 3'b010, 3'b010, 3'b100};
    logic [31:0] p1_d  [4] = '{32'h0000_0005, 32'hB0D1_0001, 32'hB0D1_0002, 32'h7A11_0003};
    logic        t1_ov [8] = '{0, 1, 1, 1, 1, 0, 0, 0};
    logic        t1_req[8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    logic [2:0]  t5_id [4] = '{3'b001, 3'b100, 3'b001, 3'b100};
    logic [31:0] t5_d  [4] = '{32'h0000_0009, 32'h0000_1111, 32'h0000_000A, 32'h0000_2222};
    logic        t5_req[10] = '{0, 1, 1, 1, 0, 1, 1, 1, 0, 0};
    logic        t5_ov [10] = '{0, 0, 0, 1, 1, 0, 0, 1, 1, 0};

    noc_port_requester #(.DATA_W(32), .DEPTH(8), .PORT_SEL(PS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_flit(in_flit), .in_id(in_id), .grant(grant), .req(req),
        .flit_id(flit_id), .length(length), .out_valid(out_valid),
        .out_flit(out_flit), .out_id(out_id), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] id, input logic [31:0] d);
        in_valid = 1'b1;
        in_id    = id;
        in_flit  = d;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_flit = '0; in_id = '0; grant = '0;
        step(); step();
        chk("rst_req", 32'(req), 0);
        chk("rst_ov", 32'(out_valid), 0);
        chk("rst_oflit", out_flit, 0);
        chk("rst_oid", 32'(out_id), 0);
        chk("rst_len", 32'(length), 0);
        chk("rst_err", 32'(err_count), 0);
        chk("rst_rdy", 32'(in_ready), 1);
        chk("rst_fid", 32'(flit_id), 0);
        rst = 1'b0;

        // single packet, grant applied once requesting
        push(p1_id[0], p1_d[0]);
        chk("t1_fid", 32'(flit_id), 1);
        chk("t1_req0", 32'(req), 0);
        push(p1_id[1], p1_d[1]);
        chk("t1_req1", 32'(req), 1);
        chk("t1_len", 32'(length), 5);
        push(p1_id[2], p1_d[2]);
        push(p1_id[3], p1_d[3]);
        grant = PS;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("t1_ov%0d", i), 32'(out_valid), 32'(t1_ov[i]));
            chk($sformatf("t1_req%0d", i), 32'(req), 32'(t1_req[i]));
            if (out_valid && k < 4) begin
                chk($sformatf("t1_id%0d", k), 32'(out_id), 32'(p1_id[k]));
                chk($sformatf("t1_d%0d", k), out_flit, p1_d[k]);
                k++;
            end
        end
        chk("t1_len_end", 32'(length), 5);
        grant = '0;

        // grant withdrawn mid-packet
        push(3'b001, 32'h0000_0007);
        push(3'b010, 32'hC000_0001);
        push(3'b010, 32'hC000_0002);
        push(3'b100, 32'hC000_0003);
        chk("t2_len", 32'(length), 7);
        grant = PS;
        step(); chk("t2_ov_a", 32'(out_valid), 0);
        step(); chk("t2_id_h", 32'(out_id), 1); chk("t2_d_h", out_flit, 32'h0000_0007); chk("t2_ov_h", 32'(out_valid), 1);
        step(); chk("t2_id_b1", 32'(out_id), 2); chk("t2_d_b1", out_flit, 32'hC000_0001); chk("t2_ov_b1", 32'(out_valid), 1);
        grant = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("t2_stall_ov%0d", i), 32'(out_valid), 0);
            chk($sformatf("t2_stall_req%0d", i), 32'(req), 1);
        end
        grant = PS;
        step(); chk("t2_ov_re", 32'(out_valid), 0);
        step(); chk("t2_ov_b2", 32'(out_valid), 1); chk("t2_d_b2", out_flit, 32'hC000_0002);
        step(); chk("t2_ov_t", 32'(out_valid), 1); chk("t2_id_t", 32'(out_id), 4);
        chk("t2_d_t", out_flit, 32'hC000_0003); chk("t2_req_t", 32'(req), 0);
        grant = '0;
        step(); chk("t2_ov_end", 32'(out_valid), 0);

        // headerless flits are discarded
        push(3'b010, 32'hDEAD_0001);
        chk("t3_req_a", 32'(req), 0);
        push(3'b100, 32'hDEAD_0002);
        chk("t3_req_b", 32'(req), 0);
        push(3'b110, 32'hDEAD_0003);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("t3_req%0d", i), 32'(req), 0);
        end
        chk("t3_err", 32'(err_count), ERR3);
        chk("t3_fid", 32'(flit_id), 0);

        // fill to full while another port holds the grant
        grant = 6'b000100;
        push(3'b001, 32'h0000_0003);
        for (int i = 0; i < 7; i++) push(3'b010, 32'(100 + i));
        chk("t4_full", 32'(in_ready), 0);
        chk("t4_req", 32'(req), 1);
        chk("t4_fid", 32'(flit_id), 1);
        chk("t4_len", 32'(length), 3);
        push(3'b100, 32'd999);
        chk("t4_full2", 32'(in_ready), 0);
        grant = PS;
        step(); chk("t4_rdy_g1", 32'(in_ready), 0); chk("t4_ov_g1", 32'(out_valid), 0);
        step(); chk("t4_ov_h", 32'(out_valid), 1); chk("t4_d_h", out_flit, 32'h0000_0003);
        chk("t4_rdy_g2", 32'(in_ready), 1);
        cnt = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (out_valid && out_id == 3'b010 && out_flit == 32'(100 + i)) cnt++;
        end
        chk("t4_bodies", 32'(cnt), 7);
        step(); chk("t4_bubble", 32'(out_valid), 0);
        push(3'b100, 32'h0000_00EE);
        step(); chk("t4_ov_t", 32'(out_valid), 1); chk("t4_d_t", out_flit, 32'h0000_00EE);
        chk("t4_req_t", 32'(req), 0);

        // back-to-back packets with grant held
        for (int i = 0; i < 10; i++) begin
            in_valid = i < 4;
            in_id    = i < 4 ? t5_id[i] : 3'b000;
            in_flit  = i < 4 ? t5_d[i] : 32'd0;
            step();
            chk($sformatf("t5_req%0d", i), 32'(req), 32'(t5_req[i]));
            chk($sformatf("t5_ov%0d", i), 32'(out_valid), 32'(t5_ov[i]));
            if (i == 4) chk("t5_len1", 32'(length), 9);
            if (i == 5) chk("t5_len2", 32'(length), 10);
        end
        in_valid = 1'b0;

        // reset in the middle of SEND
        push(3'b001, 32'h0000_0004);
        push(3'b010, 32'hF000_0001);
        push(3'b010, 32'hF000_0002);
        push(3'b100, 32'hF000_0003);
        chk("t6_ov_pre", 32'(out_valid), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_req", 32'(req), 0);
        chk("t6_ov", 32'(out_valid), 0);
        chk("t6_fid", 32'(flit_id), 0);
        chk("t6_rdy", 32'(in_ready), 1);
        chk("t6_err", 32'(err_count), 0);
        chk("t6_len", 32'(length), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("t6_ov_after%0d", i), 32'(out_valid), 0);
            chk($sformatf("t6_req_after%0d", i), 32'(req), 0);
        end
        grant = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
